// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_adder                                               |
// | Description : Bit-serial WIDTH-bit adder, one full-adder cell plus carry |
// |               flop; LSB-first, WIDTH shift cycles, done pulse on result. |
// |               Optional signed-overflow output under SERIAL_ADDER_OVF_EN. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_s;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_rs_full;

  assign w_accept  = start && (r_state != S_SHIFT);
  assign w_shift   = (r_state == S_SHIFT);
  assign w_last    = w_shift && (r_cnt == C_LAST);
  assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c       = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  // Sum bits arrive LSB-first and enter at the top; the newest bit completes the word.
  assign w_rs_full = {w_s, r_s};

  assign sum  = r_sum;
  assign cout = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == C_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_SHIFT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_s     <= '0;
    end else if (w_shift) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_s     <= w_rs_full[WIDTH-1:1];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_rs_full;
        r_cout <= w_c;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit r_carry is the carry into the MSB and w_c the carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (w_last) begin
      ovf <= r_carry ^ w_c;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_adder                                            |
// | Description : Scoreboard bench for serial_adder (WIDTH=8).               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cin   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic             cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    logic [WIDTH:0] full;
    exp_t r;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  // Drives one accepted start and records the expected result.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(x, y, c));
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done: n = edges elapsed, bc = busy cycles seen.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!done && n < WIDTH + 4) begin
      if (busy) bc++;
      tick();
      n++;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t r;
    r = '0;
    if (sb.size() > 0) r = sb.pop_front();
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] va [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [WIDTH-1:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
    logic             vc [3] = '{1'b0, 1'b0, 1'b1};
    int n, bc;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(n, bc);
      e = pop_exp();
      total++; if (n !== WIDTH) begin bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, n, WIDTH); end
      total++; if (bc !== WIDTH) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, WIDTH); end
      total++; if (sum !== e.sum) begin bad++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum, e.sum); end
      total++; if (cout !== e.cout) begin bad++; $display("FAIL dir%0d_cout: got %b expected %b", i, cout, e.cout); end
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL dir%0d_pulse: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    exp_t first;
    issue(8'h12, 8'h34, 1'b0);
    wait_done(n, bc);
    first = pop_exp();
    total++; if (sum !== first.sum) begin bad++; $display("FAIL b2b_first_sum: got %h expected %h", sum, first.sum); end
    issue(8'hA5, 8'h5A, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    total++; if (sum !== first.sum) begin bad++; $display("FAIL b2b_hold_sum: got %h expected %h", sum, first.sum); end
    wait_done(n, bc);
    e = pop_exp();
    total++; if (n + 1 !== WIDTH + 1) begin bad++; $display("FAIL b2b_spacing: got %0d expected %0d", n + 1, WIDTH + 1); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL b2b_sum: got %h expected %h", sum, e.sum); end
    total++; if (cout !== e.cout) begin bad++; $display("FAIL b2b_cout: got %b expected %b", cout, e.cout); end
    tick();
  endtask

  task automatic test_ignore_start;
    int n, bc;
    issue(8'h3C, 8'h0F, 1'b1);
    tick();
    tick();
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    e = pop_exp();
    total++; if (n + 3 !== WIDTH) begin bad++; $display("FAIL ignore_latency: got %0d expected %0d", n + 3, WIDTH); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL ignore_sum: got %h expected %h", sum, e.sum); end
    total++; if (cout !== e.cout) begin bad++; $display("FAIL ignore_cout: got %b expected %b", cout, e.cout); end
    tick();
  endtask

  task automatic test_reset_abort;
    int n, bc, seen;
    issue(8'h55, 8'h66, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    total++; if (sum !== '0) begin bad++; $display("FAIL abort_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort_cout: got %b expected 0", cout); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (done) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
    issue(8'h9A, 8'h27, 1'b1);
    wait_done(n, bc);
    e = pop_exp();
    total++; if (n !== WIDTH) begin bad++; $display("FAIL abort_fresh_latency: got %0d expected %0d", n, WIDTH); end
    total++; if ({cout, sum} !== {e.cout, e.sum}) begin
      bad++; $display("FAIL abort_fresh_result: got %b_%h expected %b_%h", cout, sum, e.cout, e.sum);
    end
    tick();
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    logic [WIDTH-1:0] va [3] = '{8'h7F, 8'h80, 8'h01};
    logic [WIDTH-1:0] vb [3] = '{8'h01, 8'hFF, 8'h01};
    int n, bc;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 1'b0);
      wait_done(n, bc);
      e = pop_exp();
      total++; if (ovf !== e.ovf) begin bad++; $display("FAIL ovf%0d_ovf: got %b expected %b", i, ovf, e.ovf); end
      total++; if (cout !== e.cout) begin bad++; $display("FAIL ovf%0d_cout: got %b expected %b", i, cout, e.cout); end
      tick();
    end
  endtask
`endif

  task automatic test_random;
    int n, bc;
    for (int i = 0; i < 1000; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      wait_done(n, bc);
      e = pop_exp();
      total++; if (n !== WIDTH) begin bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, n, WIDTH); end
      total++; if ({cout, sum} !== {e.cout, e.sum}) begin
        bad++; $display("FAIL rand%0d_result: got %b_%h expected %b_%h", i, cout, sum, e.cout, e.sum);
      end
`ifdef SERIAL_ADDER_OVF_EN
      total++; if (ovf !== e.ovf) begin bad++; $display("FAIL rand%0d_ovf: got %b expected %b", i, ovf, e.ovf); end
`endif
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
